// File: rtl/cnt_ctrl_if.sv
// Button inputs and counter-control outputs of cnt_ctrl, bundled for port connection.
// The slave modport is the controller; the master modport is whatever drives the buttons.
interface cnt_ctrl_if;
   logic [2:0] i_Push;
   logic       o_Inc;
   logic       o_Dec;
   logic       o_Wrap;
   logic [3:0] o_Cnt;
   logic [3:0] o_LED;
   logic [1:0] o_Mode;

   modport master (
      output i_Push,
      input  o_Inc, o_Dec, o_Wrap, o_Cnt, o_LED, o_Mode
   );

   modport slave (
      input  i_Push,
      output o_Inc, o_Dec, o_Wrap, o_Cnt, o_LED, o_Mode
   );
endinterface

// File: rtl/cnt_ctrl.sv
// Push-button counter controller: manual stepping, auto up/down stepping on a prescaled tick,
// and pause; a mode button cycles the four states.
module cnt_ctrl #(
   parameter int unsigned TICK_DIV = 50000000,
   parameter int unsigned CNT_MAX  = 15
) (
   input logic        i_Clk,
   input logic        i_Rst,
   cnt_ctrl_if.slave  ctrl_io
);

   typedef enum logic [1:0] {
      StMan    = 2'd0,
      StAutoUp = 2'd1,
      StAutoDn = 2'd2,
      StPause  = 2'd3
   } state_e;

   localparam int unsigned       PreW    = $clog2(TICK_DIV);
   localparam logic [PreW-1:0]   PreLast = PreW'(TICK_DIV - 1);
   localparam logic [3:0]        CntTop  = 4'(CNT_MAX);

   logic [2:0]      sync1_q, sync2_q, prev_q;
   logic [2:0]      press_q, press_d;
   logic [1:0]      arm_q, arm_d;
   logic            armed;

   state_e          state_q, state_d;
   logic [PreW-1:0] pre_q, pre_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            inc_q, inc_d;
   logic            dec_q, dec_d;
   logic            wrap_q, wrap_d;
   logic            auto_st;
   logic            tick;

   // Edges are only trusted once the synchronizer and edge flop hold post-reset samples, so a
   // button held through reset release never looks like a fresh press.
   assign armed   = (arm_q == 2'd3);
   assign arm_d   = armed ? arm_q : arm_q + 2'd1;
   assign press_d = armed ? (prev_q & ~sync2_q) : 3'b000;

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         sync1_q <= 3'b111;
         sync2_q <= 3'b111;
         prev_q  <= 3'b111;
         press_q <= 3'b000;
         arm_q   <= 2'd0;
      end else begin
         sync1_q <= ctrl_io.i_Push;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         press_q <= press_d;
         arm_q   <= arm_d;
      end
   end

   assign auto_st = (state_q == StAutoUp) || (state_q == StAutoDn);
   assign tick    = auto_st && (pre_q == PreLast);

   always_comb begin
      state_d = state_q;
      pre_d   = '0;
      inc_d   = 1'b0;
      dec_d   = 1'b0;
      if (press_q[2]) begin
         // A mode press wins over everything else and restarts the prescaler.
         unique case (state_q)
            StMan:    state_d = StAutoUp;
            StAutoUp: state_d = StAutoDn;
            StAutoDn: state_d = StPause;
            StPause:  state_d = StMan;
            default:  state_d = StMan;
         endcase
      end else begin
         if (auto_st) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
         end
         unique case (state_q)
            StMan: begin
               inc_d = press_q[1] & ~press_q[0];
               dec_d = press_q[0] & ~press_q[1];
            end
            StAutoUp: inc_d = tick;
            StAutoDn: dec_d = tick;
            default: ;
         endcase
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (inc_d) begin
         if (cnt_q == CntTop) begin
            cnt_d  = 4'd0;
            wrap_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end else if (dec_d) begin
         if (cnt_q == 4'd0) begin
            cnt_d  = CntTop;
            wrap_d = 1'b1;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
      end
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_q <= StMan;
         pre_q   <= '0;
         cnt_q   <= 4'd0;
         inc_q   <= 1'b0;
         dec_q   <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         cnt_q   <= cnt_d;
         inc_q   <= inc_d;
         dec_q   <= dec_d;
         wrap_q  <= wrap_d;
      end
   end

   assign ctrl_io.o_Inc  = inc_q;
   assign ctrl_io.o_Dec  = dec_q;
   assign ctrl_io.o_Wrap = wrap_q;
   assign ctrl_io.o_Cnt  = cnt_q;
   assign ctrl_io.o_LED  = cnt_q;
   assign ctrl_io.o_Mode = state_q;

endmodule

// File: tb/tb_cnt_ctrl.sv
// Randomized bench for cnt_ctrl: a cycle-numbered reference model queues expected steps and a
// negedge monitor pops and compares them whenever the DUT strobes o_Inc/o_Dec.
module tb_cnt_ctrl;
   localparam int TickDiv = 4;
   localparam int CntMax  = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] push = 3'b111;

   cnt_ctrl_if bus ();
   assign bus.i_Push = push;

   cnt_ctrl #(
      .TICK_DIV (TickDiv),
      .CNT_MAX  (CntMax)
   ) dut (
      .i_Clk   (clk),
      .i_Rst   (rst),
      .ctrl_io (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      bit inc;
      int cnt;
      bit wrap;
   } step_t;

   step_t    exp_q[$];
   bit [2:0] sched[int];   // press effects keyed by the clock edge they land on
   int       cyc;
   int       m_mode, m_cnt, m_entry;
   int       n_tests = 0, n_fail = 0;
   int       n_inc = 0, n_wrap = 0, n_step = 0;

   task automatic check(input string name, input int act, input int want);
      n_tests++;
      if (act != want) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, want);
      end
   endtask

   // Reference model: edges numbered from reset release; auto steps fall on multiples of
   // TickDiv after the edge that entered the auto state.
   initial begin
      bit [2:0] ev;
      bit       st, up, wr;
      forever begin
         @(posedge clk);
         if (rst) begin
            cyc = 0; m_mode = 0; m_cnt = 0; m_entry = 0;
            sched.delete();
         end else begin
            cyc++;
            ev = sched.exists(cyc) ? sched[cyc] : 3'b000;
            st = 1'b0; up = 1'b0; wr = 1'b0;
            if (ev[2]) begin
               m_mode  = (m_mode + 1) % 4;
               m_entry = cyc;
            end else if (m_mode == 0) begin
               if (ev[1] != ev[0]) begin st = 1'b1; up = ev[1]; end
            end else if (m_mode == 1 || m_mode == 2) begin
               if ((cyc - m_entry) % TickDiv == 0) begin st = 1'b1; up = (m_mode == 1); end
            end
            if (st) begin
               if (up) begin wr = (m_cnt == CntMax); m_cnt = wr ? 0 : m_cnt + 1; end
               else    begin wr = (m_cnt == 0);      m_cnt = wr ? CntMax : m_cnt - 1; end
               exp_q.push_back('{cyc: cyc, inc: up, cnt: m_cnt, wrap: wr});
            end
         end
      end
   end

   initial begin
      step_t e;
      bit    stp;
      forever begin
         @(negedge clk);
         if (rst) begin
            check("rst_inc", int'(bus.o_Inc), 0);
            check("rst_dec", int'(bus.o_Dec), 0);
            check("rst_wrap", int'(bus.o_Wrap), 0);
            check("rst_cnt", int'(bus.o_Cnt), 0);
            check("rst_mode", int'(bus.o_Mode), 0);
            exp_q.delete();
         end else begin
            stp = bus.o_Inc | bus.o_Dec;
            check("inc_dec_exclusive", int'(bus.o_Inc & bus.o_Dec), 0);
            if (bus.o_Wrap) n_wrap++;
            if (stp) begin
               n_step++;
               if (bus.o_Inc) n_inc++;
               if (exp_q.size() == 0) begin
                  check("unexpected_step", int'(stp), 0);
               end else begin
                  e = exp_q.pop_front();
                  check("step_cycle", cyc, e.cyc);
                  check("step_dir_inc", int'(bus.o_Inc), int'(e.inc));
                  check("step_cnt", int'(bus.o_Cnt), e.cnt);
                  check("step_wrap", int'(bus.o_Wrap), int'(e.wrap));
               end
            end else begin
               check("wrap_without_step", int'(bus.o_Wrap), 0);
               if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                  e = exp_q.pop_front();
                  check("missing_step", int'(stp), 1);
               end
            end
            check("mode", int'(bus.o_Mode), m_mode);
            check("cnt", int'(bus.o_Cnt), m_cnt);
            check("led", int'(bus.o_LED), m_cnt);
         end
      end
   end

   // Called at a negedge: the new level is sampled on the next edge and acts three edges later.
   task automatic press(input bit [2:0] mask, input int hold, input int gap);
      if (!rst) sched[cyc + 4] = (sched.exists(cyc + 4) ? sched[cyc + 4] : 3'b000) | mask;
      push = push & ~mask;
      repeat (hold) @(negedge clk);
      push = push | mask;
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_cyc(input int t);
      int g = 0;
      while (cyc < t && g < 500) begin
         @(negedge clk);
         g++;
      end
      if (cyc < t) check("wait_timeout", cyc, t);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   initial begin
      int ent, base, n0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Three manual up presses
      base = n_wrap;
      for (int i = 0; i < 3; i++) press(3'b010, 2, 3);
      repeat (6) @(negedge clk);
      check("up3_cnt", int'(bus.o_Cnt), 3);
      check("up3_no_wrap", n_wrap - base, 0);

      // Down from zero wraps to the top value
      do_reset(2);
      base = n_wrap;
      press(3'b001, 2, 3);
      repeat (6) @(negedge clk);
      check("down_wrap_cnt", int'(bus.o_Cnt), CntMax);
      check("down_wrap_pulses", n_wrap - base, 1);

      // Enter AUTO_UP and count increments over 20 cycles
      ent = cyc + 4;
      press(3'b100, 1, 0);
      wait_cyc(ent);
      base = n_inc;
      wait_cyc(ent + 21);
      check("auto_up_mode", int'(bus.o_Mode), 1);
      check("auto_up_incs", n_inc - base, 5);

      // Mode press landing on a tick edge
      n0 = 0;
      while ((cyc - ent) % TickDiv != 0 && n0 < 8) begin
         @(negedge clk);
         n0++;
      end
      base = cyc;
      press(3'b100, 1, 0);
      wait_cyc(base + 4);
      check("tick_mode_mode", int'(bus.o_Mode), 2);
      check("tick_mode_no_step", int'(bus.o_Inc | bus.o_Dec), 0);
      wait_cyc(base + 8);
      check("tick_mode_next_dec", int'(bus.o_Dec), 1);

      // Reset in the middle of AUTO_DN, away from the clock edge
      repeat (6) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_no_step", int'(bus.o_Inc | bus.o_Dec), 0);
      check("post_rst_mode", int'(bus.o_Mode), 0);
      repeat (4) @(negedge clk);

      // Up and down on the same edge in MAN
      press(3'b011, 2, 6);
      check("updn_cnt", int'(bus.o_Cnt), 0);

      // Buttons held through reset release
      @(negedge clk);
      rst  = 1'b1;
      push = 3'b000;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      base = n_step;
      repeat (6) @(negedge clk);
      push = 3'b111;
      repeat (10) @(negedge clk);
      check("held_rst_mode", int'(bus.o_Mode), 0);
      check("held_rst_cnt", int'(bus.o_Cnt), 0);
      check("held_rst_steps", n_step - base, 0);

      // Random presses across all modes
      for (int i = 0; i < 250; i++) begin
         bit [2:0] m;
         m = ($urandom_range(0, 3) == 0) ? 3'(3'b100 | 3'($urandom_range(0, 3)))
                                         : 3'($urandom_range(1, 3));
         press(m, $urandom_range(1, 3), $urandom_range(2, 6));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 12)) @(negedge clk);
      end
      repeat (8) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cnt_ctrl.md
CNT_CTRL -- requirements
Module: cnt_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000, sets clock cycles per auto-step tick (1 Hz at 50 MHz); legal range 2..2^26.
REQ-002 Parameter CNT_MAX, default 15, sets the top value of the 4-bit count; legal range 1..15.
REQ-003 i_Clk  input  1  system clock, 50 MHz.
REQ-004 i_Rst  input  1  reset, asynchronous, active-high.
REQ-005 i_Push  input  3  raw push buttons, active-low, asynchronous to i_Clk: [2] mode, [1] up, [0] down.
REQ-006 o_Inc  output  1  one-cycle increment strobe to the counter datapath.
REQ-007 o_Dec  output  1  one-cycle decrement strobe to the counter datapath.
REQ-008 o_Cnt  output  4  shadow count value.
REQ-009 o_Wrap  output  1  one-cycle pulse on a count wrap in either direction.
REQ-010 o_Mode  output  2  current state code: MAN=0, AUTO_UP=1, AUTO_DN=2, PAUSE=3.
REQ-011 o_LED  output  4  equals o_Cnt.

Function
REQ-012 Each i_Push bit SHALL pass through a 2-flop synchronizer; a press SHALL be detected as a 1->0 transition of the synchronized bit, one event per press.
REQ-013 A press sampled at rising edge k SHALL produce its step at edge k+3: o_Inc/o_Dec high for the cycle after edge k+3, o_Cnt updated at edge k+3.
REQ-014 FSM SHALL cycle MAN -> AUTO_UP -> AUTO_DN -> PAUSE -> MAN, one state per mode press; there are no other transitions.
REQ-015 In MAN, an up press SHALL issue one increment; a down press SHALL issue one decrement; up and down detected in the same cycle SHALL issue no step.
REQ-016 In AUTO_UP/AUTO_DN, each tick SHALL issue one increment/decrement respectively; up/down presses SHALL be ignored.
REQ-017 In PAUSE, no step SHALL be issued; up/down presses SHALL be ignored.
REQ-018 Prescaler SHALL count 0..TICK_DIV-1 only in AUTO_UP/AUTO_DN, assert tick when at TICK_DIV-1 and return to 0; it SHALL be held at 0 in MAN/PAUSE and cleared on every state change.
REQ-019 First auto step after entering an AUTO state SHALL occur exactly TICK_DIV cycles after the state change.
REQ-020 Priority per cycle: mode press > up/down press > tick; a mode press SHALL suppress any step in that cycle.
REQ-021 Increment at CNT_MAX SHALL load 0 and pulse o_Wrap; decrement at 0 SHALL load CNT_MAX and pulse o_Wrap.
REQ-022 o_Inc and o_Dec SHALL never be high in the same cycle; at most one step per cycle.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 On i_Rst high: state MAN, o_Cnt=0, o_Inc=o_Dec=o_Wrap=0, o_Mode=0, prescaler=0, all synchronizer and edge flops =1 (released), asynchronously and held while i_Rst is high.
REQ-025 Buttons held pressed through reset release SHALL NOT produce a press event.
REQ-026 Reset asserted mid-AUTO SHALL discard any pending step; the first cycle after release issues no step.

Verification (TICK_DIV=4, CNT_MAX=15)
REQ-027 Reset, up press x3 in MAN -> three o_Inc pulses, o_Cnt=3, o_Wrap never high.
REQ-028 From o_Cnt=0 in MAN, down press -> o_Dec pulse, o_Cnt=15, o_Wrap pulse same cycle.
REQ-029 Mode press once, hold 20 cycles -> o_Mode=1, o_Inc every 4 cycles starting 4 cycles after the state change, 5 increments.
REQ-030 Mode press landing in the same cycle as a tick in AUTO_UP -> o_Mode=2, no step that cycle, next step is o_Dec 4 cycles later.
REQ-031 In MAN, up and down released-to-pressed on the same edge -> no o_Inc/o_Dec, o_Cnt unchanged.
REQ-032 Hold i_Push=3'b000 during reset, release reset, then release buttons -> no press events, o_Mode=0, o_Cnt=0.
